// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg
// Shared definitions for the FIR BRAM controller and its MAC sub-module.
//   - fir_state_t : sequencer state encoding
//   - FIR_NTAP / FIR_DW / FIR_AW : default tap count, data width, RAM byte-address width
//   - wrap_sub()  : circular-buffer index arithmetic, (wp - k) mod ntap
package fir_ctrl_pkg;

    localparam int FIR_NTAP = 11;
    localparam int FIR_DW   = 32;
    localparam int FIR_AW   = 12;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_IN,
        MAC,
        OUT,
        DONE
    } fir_state_t;

    // Both operands are already in 0..ntap-1, so a single conditional add
    // is enough to bring a negative difference back into range.
    function automatic int wrap_sub(input int wp, input int k, input int ntap = FIR_NTAP);
        return (wp >= k) ? (wp - k) : (wp + ntap - k);
    endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac
// Registered signed multiply-accumulate. Product and sum are truncated to
// DW bits (two's complement wrap, no saturation).
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears the accumulator)
//   clr      : clear accumulator on this edge (has priority over en)
//   en       : add a*b to the accumulator on this edge
//   a, b     : signed operands
//   acc      : current accumulator value
module fir_mac
    import fir_ctrl_pkg::*;
#(
    parameter int DW = FIR_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] acc
);

    logic signed [DW-1:0] acc_q;
    logic signed [DW-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + a * b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_bram_ctrl.sv
// fir_bram_ctrl
// Sequencer/arbiter for the FIR tap RAM and data RAM (byte-write WE[3:0],
// byte address A, combinational read Do). Per output sample it accepts one
// input sample into a circular data buffer, runs an NTAP-cycle MAC over the
// tap/data pairs and presents the result on the output stream.
// Build option: define FIR_CFG_ARB_EN to let the host cfg_* port reach the
// tap RAM while the engine is in IDLE or DONE; otherwise cfg_ready and
// cfg_rdata stay 0 and the tap RAM is only ever read by the engine.
// Ports:
//   CLK, RST                  : clock, synchronous active-high reset
//   ap_start/ap_idle/ap_done  : block control, data_length sampled on start
//   ss_valid/ss_ready/ss_data : input sample stream
//   sm_valid/sm_ready/sm_data/sm_last : output sample stream
//   cfg_*                     : host tap RAM access
//   tap_* / dat_*             : tap RAM and data RAM interfaces
module fir_bram_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int NTAP = FIR_NTAP,
    parameter int DW   = FIR_DW,
    parameter int AW   = FIR_AW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ap_start,
    input  logic [31:0]   data_length,
    output logic          ap_idle,
    output logic          ap_done,
    input  logic          ss_valid,
    output logic          ss_ready,
    input  logic [DW-1:0] ss_data,
    output logic          sm_valid,
    input  logic          sm_ready,
    output logic [DW-1:0] sm_data,
    output logic          sm_last,
    input  logic          cfg_valid,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    output logic          cfg_ready,
    output logic [DW-1:0] cfg_rdata,
    output logic          tap_EN,
    output logic [3:0]    tap_WE,
    output logic [AW-1:0] tap_A,
    output logic [DW-1:0] tap_Di,
    input  logic [DW-1:0] tap_Do,
    output logic          dat_EN,
    output logic [3:0]    dat_WE,
    output logic [AW-1:0] dat_A,
    output logic [DW-1:0] dat_Di,
    input  logic [DW-1:0] dat_Do
);

    localparam int IW = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NTAP - 1);

    fir_state_t    state_q, state_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [IW-1:0] wp_q, wp_d;
    logic [IW-1:0] k_q, k_d;
    logic          acc_clr;
    logic          acc_en;
    logic [DW-1:0] acc;
    logic [IW-1:0] dat_idx;

    // Word index to byte address.
    function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] idx);
        return AW'(idx) << 2;
    endfunction

    // The newest sample sits at wp, so tap k pairs with the sample k steps older.
    assign dat_idx = IW'(wrap_sub(int'(wp_q), int'(k_q), NTAP));

    fir_mac #(.DW(DW)) u_mac (
        .clk (CLK),
        .rst (RST),
        .clr (acc_clr),
        .en  (acc_en),
        .a   (tap_Do),
        .b   (dat_Do),
        .acc (acc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            k_q     <= k_d;
        end
    end

    // k doubles as the INIT word counter and the MAC tap counter; both phases
    // always leave it at 0 for whichever phase comes next.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wp_d    = wp_q;
        k_d     = k_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ap_start) begin
                    len_d   = data_length;
                    cnt_d   = '0;
                    wp_d    = '0;
                    k_d     = '0;
                    acc_clr = 1'b1;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (k_q == LAST_IDX) begin
                    k_d     = '0;
                    state_d = (len_q == '0) ? DONE : WAIT_IN;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            WAIT_IN: begin
                if (ss_valid) begin
                    k_d     = '0;
                    acc_clr = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_en = 1'b1;
                if (k_q == LAST_IDX) begin
                    k_d     = '0;
                    state_d = OUT;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            OUT: begin
                if (sm_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    wp_d    = (wp_q == LAST_IDX) ? '0 : wp_q + IW'(1);
                    state_d = (cnt_d == len_q) ? DONE : WAIT_IN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output defaults to 0 so reset (IDLE, no host request) drives
    // only ap_idle high.
    always_comb begin
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ss_ready  = 1'b0;
        sm_valid  = 1'b0;
        sm_data   = '0;
        sm_last   = 1'b0;
        cfg_ready = 1'b0;
        cfg_rdata = '0;
        tap_EN    = 1'b0;
        tap_WE    = 4'h0;
        tap_A     = '0;
        tap_Di    = '0;
        dat_EN    = 1'b0;
        dat_WE    = 4'h0;
        dat_A     = '0;
        dat_Di    = '0;
        unique case (state_q)
            IDLE: begin
                ap_idle = 1'b1;
            end
            INIT: begin
                dat_EN = 1'b1;
                dat_WE = 4'hF;
                dat_A  = addr_of(k_q);
            end
            WAIT_IN: begin
                ss_ready = 1'b1;
                if (ss_valid) begin
                    dat_EN = 1'b1;
                    dat_WE = 4'hF;
                    dat_A  = addr_of(wp_q);
                    dat_Di = ss_data;
                end
            end
            MAC: begin
                tap_EN = 1'b1;
                tap_A  = addr_of(k_q);
                dat_EN = 1'b1;
                dat_A  = addr_of(dat_idx);
            end
            OUT: begin
                sm_valid = 1'b1;
                sm_data  = acc;
                sm_last  = (cnt_q == len_q - 32'd1);
            end
            DONE: begin
                ap_done = 1'b1;
            end
            default: begin
                ap_idle = 1'b0;
            end
        endcase
`ifdef FIR_CFG_ARB_EN
        if ((state_q == IDLE || state_q == DONE) && cfg_valid) begin
            cfg_ready = 1'b1;
            tap_EN    = 1'b1;
            tap_WE    = cfg_we ? 4'hF : 4'h0;
            tap_A     = cfg_addr;
            tap_Di    = cfg_wdata;
            cfg_rdata = tap_Do;
        end
`endif
    end

`ifndef FIR_CFG_ARB_EN
    // The host port exists in every build but goes nowhere without arbitration.
    logic unused_cfg;
    assign unused_cfg = ^{cfg_valid, cfg_we, cfg_addr, cfg_wdata};
`endif

endmodule

// File: tb/tb_fir_bram_ctrl.sv
// tb_fir_bram_ctrl
// Bench for fir_bram_ctrl with behavioural tap/data RAMs. Expected filter
// outputs come from a direct convolution of the tap table with the input
// sequence (history before the first sample is zero).
// Honours FIR_CFG_ARB_EN the same way the design does.
`timescale 1ns/1ps
module tb_fir_bram_ctrl;

    localparam int NTAP = 11;
    localparam int DW   = 32;
    localparam int AW   = 12;
`ifdef FIR_CFG_ARB_EN
    localparam bit ARB = 1'b1;
`else
    localparam bit ARB = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          ap_start;
    logic [31:0]   data_length;
    logic          ap_idle, ap_done;
    logic          ss_valid, ss_ready;
    logic [DW-1:0] ss_data;
    logic          sm_valid, sm_ready, sm_last;
    logic [DW-1:0] sm_data;
    logic          cfg_valid, cfg_we, cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata, cfg_rdata;
    logic          tap_EN, dat_EN;
    logic [3:0]    tap_WE, dat_WE;
    logic [AW-1:0] tap_A, dat_A;
    logic [DW-1:0] tap_Di, dat_Di, tap_Do, dat_Do;

    logic [DW-1:0] tap_mem [0:1023];
    logic [DW-1:0] dat_mem [0:1023];

    int taps [0:NTAP-1];
    int xin  [0:63];
    int expq [$];
    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    logic any_out;

    fir_bram_ctrl #(.NTAP(NTAP), .DW(DW), .AW(AW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ap_start    (ap_start),
        .data_length (data_length),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .ss_valid    (ss_valid),
        .ss_ready    (ss_ready),
        .ss_data     (ss_data),
        .sm_valid    (sm_valid),
        .sm_ready    (sm_ready),
        .sm_data     (sm_data),
        .sm_last     (sm_last),
        .cfg_valid   (cfg_valid),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_ready   (cfg_ready),
        .cfg_rdata   (cfg_rdata),
        .tap_EN      (tap_EN),
        .tap_WE      (tap_WE),
        .tap_A       (tap_A),
        .tap_Di      (tap_Di),
        .tap_Do      (tap_Do),
        .dat_EN      (dat_EN),
        .dat_WE      (dat_WE),
        .dat_A       (dat_A),
        .dat_Di      (dat_Di),
        .dat_Do      (dat_Do)
    );

    always #5 CLK = ~CLK;

    // Combinational-read, byte-write RAM models.
    assign tap_Do = tap_mem[tap_A[AW-1:2]];
    assign dat_Do = dat_mem[dat_A[AW-1:2]];

    always @(posedge CLK) begin
        for (int b = 0; b < 4; b++) begin
            if (tap_EN && tap_WE[b]) tap_mem[tap_A[AW-1:2]][8*b +: 8] <= tap_Di[8*b +: 8];
            if (dat_EN && dat_WE[b]) dat_mem[dat_A[AW-1:2]][8*b +: 8] <= dat_Di[8*b +: 8];
        end
    end

    assign any_out = ap_done | ss_ready | sm_valid | sm_last | cfg_ready | tap_EN | dat_EN |
                     (|tap_WE) | (|dat_WE) | (|tap_A) | (|dat_A) | (|tap_Di) | (|dat_Di) |
                     (|sm_data) | (|cfg_rdata);

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // y[n] = sum_j taps[j] * x[n-j], 32-bit wrapping arithmetic.
    function automatic void buildExpected(input int len);
        int s;
        expq.delete();
        for (int n = 0; n < len; n++) begin
            s = 0;
            for (int j = 0; j < NTAP; j++) begin
                if (n - j >= 0) s += taps[j] * xin[n - j];
            end
            expq.push_back(s);
        end
    endfunction

    task automatic loadTaps();
        for (int i = 0; i < NTAP; i++) tap_mem[i] <= taps[i];
        @(posedge CLK);
        #1;
    endtask

    // Output stream checker: every valid cycle must show the oldest pending
    // expected value, last only on the final one, and no input acceptance.
    always @(negedge CLK) begin
        if (cmp_en && sm_valid) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_output", 1, 0);
            end else begin
                checkOutput("sm_data", int'(sm_data), expq[0]);
                checkOutput("sm_last", int'(sm_last), int'(expq.size() == 1));
                checkOutput("ss_ready_during_out", int'(ss_ready), 0);
                if (sm_ready) void'(expq.pop_front());
            end
        end
    end

    // One complete job: start pulse, feed xin[0..len-1], drain outputs,
    // optionally stall output stall_idx for 5 valid cycles, optionally hold
    // a host read request for the whole job.
    task automatic applyStimulus(input int len, input int stall_idx, input bit cfg_hold);
        int iter, in_idx, out_done, stall_left, ready_cnt;
        int first_ready, first_hs, done_iter, last_out_iter;
        int valid_iter [$];
        bit done_seen, hs_in, hs_out, prev_valid;
        iter = 0; in_idx = 0; out_done = 0; ready_cnt = 0;
        first_ready = -1; first_hs = -1; done_iter = -1; last_out_iter = -1;
        done_seen = 1'b0; prev_valid = 1'b0;
        stall_left = (stall_idx >= 0) ? 5 : 0;
        @(posedge CLK);
        #1;
        ap_start    = 1'b1;
        data_length = len;
        ss_valid    = (len > 0);
        ss_data     = xin[0];
        sm_ready    = !(out_done == stall_idx && stall_left > 0);
        cfg_valid   = cfg_hold;
        cfg_we      = 1'b0;
        cfg_addr    = 12'd8;
        cmp_en      = 1'b1;
        @(negedge CLK);
        checkOutput("start_cfg_ready", int'(cfg_ready), int'(cfg_hold && ARB));
        checkOutput("start_cfg_rdata", int'(cfg_rdata), (cfg_hold && ARB) ? taps[2] : 0);
        @(posedge CLK);
        #1;
        ap_start = 1'b0;
        while (!done_seen && iter < 2000) begin
            @(negedge CLK);
            iter++;
            hs_in  = ss_valid && ss_ready;
            hs_out = sm_valid && sm_ready;
            if (ss_ready) begin
                ready_cnt++;
                if (first_ready < 0) first_ready = iter;
            end
            if (hs_in && first_hs < 0) first_hs = iter;
            if (sm_valid && !prev_valid) valid_iter.push_back(iter);
            prev_valid = sm_valid;
            if (sm_valid && !sm_ready && stall_left > 0) stall_left--;
            if (hs_out) begin
                out_done++;
                last_out_iter = iter;
            end
            if (ap_done) begin
                done_seen = 1'b1;
                done_iter = iter;
                checkOutput("done_cfg_ready", int'(cfg_ready), int'(cfg_hold && ARB));
            end else if (!ap_idle) begin
                checkOutput("busy_cfg_ready", int'(cfg_ready), 0);
            end
            @(posedge CLK);
            #1;
            if (hs_in) begin
                in_idx++;
                ss_valid = (in_idx < len);
                ss_data  = (in_idx < len) ? xin[in_idx] : 0;
            end
            sm_ready = !(out_done == stall_idx && stall_left > 0);
        end
        ss_valid  = 1'b0;
        cfg_valid = 1'b0;
        checkOutput("job_timeout", int'(done_seen), 1);
        checkOutput("outputs_left", expq.size(), 0);
        if (len == 0) begin
            checkOutput("len0_ss_ready_count", ready_cnt, 0);
            checkOutput("len0_done_iter", done_iter, NTAP + 1);
        end else begin
            checkOutput("start_to_ss_ready", first_ready, NTAP + 1);
            checkOutput("done_after_last_out", done_iter, last_out_iter + 1);
            if (valid_iter.size() == 0) begin
                checkOutput("no_output_seen", 0, 1);
            end else begin
                checkOutput("in_to_sm_valid", valid_iter[0] - first_hs, NTAP + 1);
                if (stall_idx < 0 && valid_iter.size() >= 2)
                    checkOutput("throughput", valid_iter[1] - valid_iter[0], NTAP + 2);
            end
        end
        @(negedge CLK);
        checkOutput("done_single_pulse", int'(ap_done), 0);
        checkOutput("idle_after_done", int'(ap_idle), 1);
        cmp_en   = 1'b0;
        sm_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        int dones;
        RST = 1'b1; ap_start = 1'b0; data_length = '0;
        ss_valid = 1'b0; ss_data = '0; sm_ready = 1'b0;
        cfg_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        for (int i = 0; i < 1024; i++) begin
            tap_mem[i] <= '0;
            dat_mem[i] <= '0;
        end

        // Reset state.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_ap_idle", int'(ap_idle), 1);
        checkOutput("reset_outputs_zero", int'(any_out), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Host port in IDLE.
        for (int i = 0; i < NTAP; i++) taps[i] = 1;
        loadTaps();
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 12'd12; cfg_wdata = 32'd7;
`ifdef FIR_CFG_ARB_EN
        @(negedge CLK);
        checkOutput("cfg_write_ready", int'(cfg_ready), 1);
        checkOutput("cfg_write_we", int'(tap_WE), 15);
        @(posedge CLK);
        #1;
        cfg_we = 1'b0;
        @(negedge CLK);
        checkOutput("cfg_read_ready", int'(cfg_ready), 1);
        checkOutput("cfg_read_we", int'(tap_WE), 0);
        checkOutput("cfg_readback", int'(cfg_rdata), 7);
`else
        @(negedge CLK);
        checkOutput("cfg_ready_disabled", int'(cfg_ready), 0);
        checkOutput("cfg_we_disabled", int'(tap_WE), 0);
        @(posedge CLK);
        #1;
        cfg_we = 1'b0;
        @(negedge CLK);
        checkOutput("cfg_rdata_disabled", int'(cfg_rdata), 0);
        checkOutput("tap3_untouched", int'(tap_mem[3]), 1);
`endif
        @(posedge CLK);
        #1;
        cfg_valid = 1'b0;

        // len = 0: INIT straight to DONE.
        for (int i = 0; i < 64; i++) xin[i] = 0;
        buildExpected(0);
        applyStimulus(0, -1, 1'b0);

        // Impulse: outputs replay the taps.
        taps = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        loadTaps();
        for (int i = 0; i < 64; i++) xin[i] = 0;
        xin[0] = 1;
        buildExpected(11);
        checkOutput("pin_impulse_1", expq[1], -10);
        checkOutput("pin_impulse_5", expq[5], 63);
        checkOutput("pin_impulse_10", expq[10], 0);
        applyStimulus(11, -1, 1'b0);

        // Step: ramp 2..22 then flat, exercising write-pointer wrap.
        for (int i = 0; i < NTAP; i++) taps[i] = 1;
        loadTaps();
        for (int i = 0; i < 64; i++) xin[i] = 2;
        buildExpected(15);
        checkOutput("pin_step_0", expq[0], 2);
        checkOutput("pin_step_10", expq[10], 22);
        checkOutput("pin_step_14", expq[14], 22);
        applyStimulus(15, -1, 1'b0);

        // Backpressure on the fourth output.
        for (int i = 0; i < 64; i++) xin[i] = i + 1;
        buildExpected(6);
        checkOutput("pin_bp_3", expq[3], 10);
        applyStimulus(6, 3, 1'b0);

        // Restart: stale buffer contents must not leak in; host request held.
        for (int i = 0; i < 64; i++) xin[i] = 0;
        xin[0] = 5;
        buildExpected(3);
        checkOutput("pin_restart_2", expq[2], 5);
        applyStimulus(3, -1, 1'b1);
        checkOutput("rezero_word5", int'(dat_mem[5]), 0);
        checkOutput("restart_word0", int'(dat_mem[0]), 5);

        // Reset in the middle of a MAC run.
        @(posedge CLK);
        #1;
        ap_start = 1'b1; data_length = 32'd2; ss_valid = 1'b1; ss_data = 32'd9;
        @(posedge CLK);
        #1;
        ap_start = 1'b0;
        seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            @(negedge CLK);
            if (ss_ready) seen = 1;
        end
        @(posedge CLK);
        #1;
        ss_valid = 1'b0;
        checkOutput("midmac_handshake", seen, 1);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("midmac_in_mac", int'(tap_EN), 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("midmac_reset_idle", int'(ap_idle), 1);
        checkOutput("midmac_reset_outputs_zero", int'(any_out), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        dones = 0;
        repeat (2 * NTAP + 4) begin
            @(negedge CLK);
            dones += int'(ap_done);
        end
        checkOutput("midmac_no_done", dones, 0);
        checkOutput("midmac_stays_idle", int'(ap_idle), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
